// File: rtl/rx_prog_timer_if.sv
// Control/status bundle between the C-PHY Rx control FSM (master) and rx_prog_timer (slave).
// The Cfg* table-write signals exist only when RX_TIMER_CFG_WR_EN is defined.
interface rx_prog_timer_if #(
  parameter int unsigned CNT_W  = 16,
  parameter int unsigned SEED_W = 3
);
  logic              TimerEn;
  logic [SEED_W-1:0] TimerSeed;
  logic              TimerMode;
  logic              Timeout;
  logic              Busy;
  logic [CNT_W-1:0]  Elapsed;
`ifdef RX_TIMER_CFG_WR_EN
  logic              CfgWr;
  logic [SEED_W-1:0] CfgAddr;
  logic [CNT_W-1:0]  CfgData;

  modport master (
    output TimerEn, TimerSeed, TimerMode, CfgWr, CfgAddr, CfgData,
    input  Timeout, Busy, Elapsed
  );
  modport slave (
    input  TimerEn, TimerSeed, TimerMode, CfgWr, CfgAddr, CfgData,
    output Timeout, Busy, Elapsed
  );
`else
  modport master (
    output TimerEn, TimerSeed, TimerMode,
    input  Timeout, Busy, Elapsed
  );
  modport slave (
    input  TimerEn, TimerSeed, TimerMode,
    output Timeout, Busy, Elapsed
  );
`endif
endinterface

// File: rtl/rx_prog_timer.sv
// Seed-indexed programmable timer for the C-PHY Rx control FSMs.
// One-shot or periodic operation, one-cycle registered Timeout pulse, Busy/Elapsed status.
// Optional feature macro: RX_TIMER_CFG_WR_EN enables runtime threshold-table writes;
// without it the table is the constant parameter defaults and costs no flops.
module rx_prog_timer #(
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned SEED_W    = 3,
  parameter int unsigned T_LP_TX   = 15,
  parameter int unsigned T_TERMEN  = 15,
  parameter int unsigned T_SETTLE  = 30,
  parameter int unsigned T_TA_SURE = 30,
  parameter int unsigned T_TA_GET  = 75,
  parameter int unsigned T_WAKE_UP = 300
) (
  input  logic            clk,
  input  logic            rst_n,
  rx_prog_timer_if.slave  tmr
);

  localparam int unsigned Depth = 32'd1 << SEED_W;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  function automatic logic [CNT_W-1:0] reset_val(input int unsigned idx);
    logic [CNT_W-1:0] v;
    case (idx)
      32'd0:   v = CNT_W'(T_LP_TX);
      32'd1:   v = CNT_W'(T_TERMEN);
      32'd2:   v = CNT_W'(T_SETTLE);
      32'd3:   v = CNT_W'(T_TA_SURE);
      32'd4:   v = CNT_W'(T_TA_GET);
      32'd5:   v = CNT_W'(T_WAKE_UP);
      default: v = '0;
    endcase
    return v;
  endfunction

  logic [CNT_W-1:0] tbl_rd;
  logic [CNT_W-1:0] thr_eff;

`ifdef RX_TIMER_CFG_WR_EN
  logic [CNT_W-1:0] table_q [Depth];

  // Threshold table: reset to defaults, rewritten by the config strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < Depth; i++) begin
        table_q[i] <= reset_val(i);
      end
    end else if (tmr.CfgWr) begin
      table_q[tmr.CfgAddr] <= tmr.CfgData;
    end
  end

  // A start on the same edge as a write reads the pre-write entry.
  assign tbl_rd = table_q[tmr.TimerSeed];
`else
  logic [CNT_W-1:0] rst_tbl [Depth];

  for (genvar g = 0; g < Depth; g++) begin : g_rst_tbl
    assign rst_tbl[g] = reset_val(g);
  end

  assign tbl_rd = rst_tbl[tmr.TimerSeed];
`endif

  // A zero entry would never expire; run it as a one-cycle period instead.
  assign thr_eff = (tbl_rd == '0) ? CNT_W'(1) : tbl_rd;

  logic [1:0]       state_q,   state_d;
  logic [CNT_W-1:0] elapsed_q, elapsed_d;
  logic [CNT_W-1:0] thr_q,     thr_d;
  logic             mode_q,    mode_d;
  logic             timeout_q, timeout_d;

  // Next-state: start latching, counting, expiry and abort.
  always_comb begin
    state_d   = state_q;
    elapsed_d = elapsed_q;
    thr_d     = thr_q;
    mode_d    = mode_q;
    timeout_d = 1'b0;
    case (state_q)
      StIdle: begin
        if (tmr.TimerEn) begin
          state_d   = StRun;
          elapsed_d = '0;
          thr_d     = thr_eff;
          mode_d    = tmr.TimerMode;
        end
      end
      StRun: begin
        if (!tmr.TimerEn) begin
          // Abort takes priority over an expiry on the same edge.
          state_d   = StIdle;
          elapsed_d = '0;
        end else if (elapsed_q == thr_q - CNT_W'(1)) begin
          timeout_d = 1'b1;
          elapsed_d = '0;
          if (!mode_q) begin
            state_d = StDone;
          end
        end else begin
          elapsed_d = elapsed_q + CNT_W'(1);
        end
      end
      StDone: begin
        elapsed_d = '0;
        // Holding TimerEn high here must not retrigger; require a low cycle first.
        if (!tmr.TimerEn) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d   = StIdle;
        elapsed_d = '0;
      end
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      elapsed_q <= '0;
      thr_q     <= CNT_W'(1);
      mode_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      elapsed_q <= elapsed_d;
      thr_q     <= thr_d;
      mode_q    <= mode_d;
      timeout_q <= timeout_d;
    end
  end

  // Outputs are straight from flops.
  always_comb begin
    tmr.Timeout = timeout_q;
    tmr.Busy    = (state_q == StRun);
    tmr.Elapsed = elapsed_q;
  end

endmodule

// File: tb/tb_rx_prog_timer.sv
// Randomized self-checking bench for rx_prog_timer against a transaction-level model:
// for a start at edge E0 the outputs after edge E0+k follow directly from k, thr and mode.
module tb_rx_prog_timer;

  localparam int unsigned CNT_W  = 16;
  localparam int unsigned SEED_W = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  rx_prog_timer_if #(.CNT_W(CNT_W), .SEED_W(SEED_W)) bus ();

  rx_prog_timer #(.CNT_W(CNT_W), .SEED_W(SEED_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .tmr   (bus)
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  int unsigned tbl_m [8];

  task automatic check_val(input string tag, input int unsigned got, input int unsigned exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_outs(input string tag, input bit to, input bit busy,
                            input int unsigned el);
    check_val({tag, ".timeout"}, 32'(bus.Timeout), 32'(to));
    check_val({tag, ".busy"},    32'(bus.Busy),    32'(busy));
    check_val({tag, ".elapsed"}, 32'(bus.Elapsed), el);
  endtask

  task automatic load_defaults();
    tbl_m = '{15, 15, 30, 30, 75, 300, 0, 0};
  endtask

  task automatic drive_cfg();
`ifdef RX_TIMER_CFG_WR_EN
    bus.CfgWr   = ($urandom_range(0, 5) == 0);
    bus.CfgAddr = 3'($urandom);
    bus.CfgData = 16'($urandom_range(0, 40));
`endif
  endtask

  // Mirror a table write that the DUT saw at the edge just taken.
  task automatic apply_cfg_model();
`ifdef RX_TIMER_CFG_WR_EN
    if (bus.CfgWr) tbl_m[bus.CfgAddr] = 32'(bus.CfgData);
`endif
  endtask

  // Start at the first edge, hold TimerEn for 'hold' edges, then low for 'gap' edges.
  task automatic run_txn(input int unsigned seed, input bit mode,
                         input int unsigned hold, input int unsigned gap);
    int unsigned thr;
    bit          e_to, e_busy;
    int unsigned e_el;
    thr = (tbl_m[seed] == 0) ? 1 : tbl_m[seed];
    for (int unsigned k = 0; k < hold; k++) begin
      bus.TimerEn = 1'b1;
      if (k == 0) begin
        bus.TimerSeed = 3'(seed);
        bus.TimerMode = mode;
      end else begin
        bus.TimerSeed = 3'($urandom);
        bus.TimerMode = 1'($urandom);
      end
      drive_cfg();
      @(posedge clk);
      #1;
      apply_cfg_model();
      if (mode) begin
        e_to   = (k > 0) && (k % thr == 0);
        e_busy = 1'b1;
        e_el   = k % thr;
      end else if (k < thr) begin
        e_to = 1'b0; e_busy = 1'b1; e_el = k;
      end else if (k == thr) begin
        e_to = 1'b1; e_busy = 1'b0; e_el = 0;
      end else begin
        e_to = 1'b0; e_busy = 1'b0; e_el = 0;
      end
      check_outs($sformatf("run s%0d m%0d k%0d", seed, mode, k), e_to, e_busy, e_el);
    end
    for (int unsigned g = 0; g < gap; g++) begin
      bus.TimerEn   = 1'b0;
      bus.TimerSeed = 3'($urandom);
      bus.TimerMode = 1'($urandom);
      drive_cfg();
      @(posedge clk);
      #1;
      apply_cfg_model();
      check_outs($sformatf("idle s%0d g%0d", seed, g), 1'b0, 1'b0, 0);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned seed, thr, hold;
    bit          mode;
    bus.TimerEn   = 1'b0;
    bus.TimerSeed = '0;
    bus.TimerMode = 1'b0;
`ifdef RX_TIMER_CFG_WR_EN
    bus.CfgWr     = 1'b0;
    bus.CfgAddr   = '0;
    bus.CfgData   = '0;
`endif
    load_defaults();
    #12;
    check_outs("reset", 1'b0, 1'b0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases from the block's intended use.
    run_txn(2, 1'b0, 40, 2);    // one-shot 30, no re-pulse while held
    run_txn(4, 1'b1, 200, 1);   // periodic 75: pulses at 75 and 150
    run_txn(5, 1'b0, 299, 2);   // abort before 300, restart two edges later
    run_txn(5, 1'b0, 305, 1);   // full 300-cycle one-shot
    run_txn(6, 1'b0, 5, 1);     // zero entry behaves as 1
    run_txn(6, 1'b1, 10, 1);    // every-cycle periodic pulse
    run_txn(0, 1'b0, 20, 1);    // seed wanders during run, latched thr holds
    run_txn(3, 1'b1, 60, 1);    // abort exactly on a periodic expiry edge

    for (int i = 0; i < 40; i++) begin
      seed = $urandom_range(0, 7);
      mode = 1'($urandom);
      thr  = (tbl_m[seed] == 0) ? 1 : tbl_m[seed];
      hold = $urandom_range(1, 2 * thr + 4);
      run_txn(seed, mode, hold, $urandom_range(1, 3));
    end

    // Asynchronous reset in the middle of a run.
    run_txn(5, 1'b1, 10, 0);
    #2;
    rst_n       = 1'b0;
    bus.TimerEn = 1'b0;
`ifdef RX_TIMER_CFG_WR_EN
    bus.CfgWr   = 1'b0;
`endif
    #1;
    check_outs("async_rst", 1'b0, 1'b0, 0);
    load_defaults();
    @(negedge clk);
    rst_n = 1'b1;
    run_txn(1, 1'b0, 20, 1);
    run_txn(4, 1'b0, 80, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
